// File: rtl/next_pc.sv
// next_pc: program-counter sequencer with an optional return-address stack.
//
// Computes the next word-addressed pc from the jump operation of the
// instruction at the current pc.
// The new pc takes effect at the same rising edge that samples the inputs,
// so there is one cycle of latency and no bubbles.
//
// Parameters
//   PC_WIDTH   program counter width, 16..32
//   RESET_PC   pc loaded on reset
//   RAS_DEPTH  return-address-stack entries, 2..16
//
// Build option
//   NEXT_PC_RAS_EN  when defined, JAL pushes pc+1 and RET pops the return
//                   address stack. When undefined there is no stack storage:
//                   JAL behaves as J, RET behaves as JR, ras_empty is tied 1
//                   and ras_full is tied 0.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous active-high reset; overrides stall and jump_op
//   stall      holds pc and the stack, and forces redirect to 0
//   jump_op    000 SEQ, 001 J, 010 BEQ, 011 BNE, 100 JAL, 101 JR, 110 RET,
//              111 reserved (treated as SEQ)
//   cmp_eq     operand-equality flag used by BEQ/BNE
//   imm26      absolute word target field for J/JAL
//   imm16      signed word branch offset for BEQ/BNE
//   jr_target  register-supplied target for JR (and RET on an empty stack)
//   pc         registered current pc
//   redirect   registered; 1 for one cycle after a non-sequential update
//   ras_empty  stack holds zero entries
//   ras_full   stack holds RAS_DEPTH entries
module next_pc #(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic [2:0]          jump_op,
    input  logic                cmp_eq,
    input  logic [25:0]         imm26,
    input  logic [15:0]         imm16,
    input  logic [PC_WIDTH-1:0] jr_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                redirect,
    output logic                ras_empty,
    output logic                ras_full
);

    localparam logic [2:0] OP_SEQ = 3'b000;
    localparam logic [2:0] OP_J   = 3'b001;
    localparam logic [2:0] OP_BEQ = 3'b010;
    localparam logic [2:0] OP_BNE = 3'b011;
    localparam logic [2:0] OP_JAL = 3'b100;
    localparam logic [2:0] OP_JR  = 3'b101;
    localparam logic [2:0] OP_RET = 3'b110;

    logic [PC_WIDTH-1:0] seq;
    logic [PC_WIDTH-1:0] br_target;
    logic [PC_WIDTH-1:0] j_target;
    logic [PC_WIDTH-1:0] target;
    logic                taken;
    logic                push;
    logic                pop;

    assign seq       = pc + PC_WIDTH'(1);
    // Size cast of a signed operand sign-extends the offset to PC_WIDTH.
    assign br_target = seq + PC_WIDTH'($signed(imm16));

    // J/JAL keep the upper pc bits of seq when the pc is wider than the field.
    generate
        if (PC_WIDTH > 26) begin : g_j_wide
            assign j_target = {seq[PC_WIDTH-1:26], imm26};
        end else begin : g_j_narrow
            logic unused_imm_hi;
            assign j_target      = imm26[PC_WIDTH-1:0];
            assign unused_imm_hi = ^imm26;
        end
    endgenerate

`ifdef NEXT_PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_WIDTH-1:0] stack_mem [RAS_DEPTH];
    // wr_ptr is the next free slot; the top entry sits just below it.
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    top_ptr;
    logic [PTR_W-1:0]    ptr_inc;
    logic [CNT_W-1:0]    count;
    logic [PC_WIDTH-1:0] top_entry;

    assign top_ptr   = (wr_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : wr_ptr - PTR_W'(1);
    assign ptr_inc   = (wr_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
    assign top_entry = stack_mem[top_ptr];
    assign ras_empty = (count == '0);
    assign ras_full  = (count == CNT_W'(RAS_DEPTH));
`else
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
`endif

    // Target selection. taken marks any redirecting path, even one whose
    // target happens to equal seq.
    always_comb begin
        target = seq;
        taken  = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        case (jump_op)
            OP_SEQ: begin
                target = seq;
            end
            OP_J: begin
                target = j_target;
                taken  = 1'b1;
            end
            OP_BEQ: begin
                if (cmp_eq) begin
                    target = br_target;
                    taken  = 1'b1;
                end
            end
            OP_BNE: begin
                if (!cmp_eq) begin
                    target = br_target;
                    taken  = 1'b1;
                end
            end
            OP_JAL: begin
                target = j_target;
                taken  = 1'b1;
`ifdef NEXT_PC_RAS_EN
                push   = 1'b1;
`endif
            end
            OP_JR: begin
                target = jr_target;
                taken  = 1'b1;
            end
            OP_RET: begin
                target = jr_target;
                taken  = 1'b1;
`ifdef NEXT_PC_RAS_EN
                if (!ras_empty) begin
                    target = top_entry;
                    pop    = 1'b1;
                end
`endif
            end
            default: begin
                target = seq;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            redirect <= 1'b0;
        end else if (stall) begin
            redirect <= 1'b0;
        end else begin
            pc       <= target;
            redirect <= taken;
        end
    end

`ifdef NEXT_PC_RAS_EN
    // Circular stack: a push when full overwrites the oldest entry and the
    // count saturates at RAS_DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (!stall) begin
            if (push) begin
                wr_ptr <= ptr_inc;
                if (!ras_full) begin
                    count <= count + CNT_W'(1);
                end
            end else if (pop) begin
                wr_ptr <= top_ptr;
                count  <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !stall && push) begin
            stack_mem[wr_ptr] <= seq;
        end
    end
`else
    logic unused_stack;
    assign unused_stack = push | pop;
`endif

endmodule

// File: tb/tb_next_pc.sv
// Directed bench for next_pc (PC_WIDTH=32, RESET_PC=0x100, RAS_DEPTH=4).
// A driver applies one vector per cycle and queues the expected outputs;
// a monitor on the falling edge pops and compares them.
module tb_next_pc;

    localparam int PCW = 32;
    localparam int EW  = PCW + 3;

    logic           clk;
    logic           rst;
    logic           stall;
    logic [2:0]     jump_op;
    logic           cmp_eq;
    logic [25:0]    imm26;
    logic [15:0]    imm16;
    logic [PCW-1:0] jr_target;
    logic [PCW-1:0] pc;
    logic           redirect;
    logic           ras_empty;
    logic           ras_full;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            total;
    int            bad;

    localparam logic [2:0] SEQ = 3'd0, J = 3'd1, BEQ = 3'd2, BNE = 3'd3;
    localparam logic [2:0] JAL = 3'd4, JR = 3'd5, RET = 3'd6, RSV = 3'd7;

`ifdef NEXT_PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    next_pc #(
        .PC_WIDTH (PCW),
        .RESET_PC (32'h100),
        .RAS_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .jump_op  (jump_op),
        .cmp_eq   (cmp_eq),
        .imm26    (imm26),
        .imm16    (imm16),
        .jr_target(jr_target),
        .pc       (pc),
        .redirect (redirect),
        .ras_empty(ras_empty),
        .ras_full (ras_full)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver: apply one vector, let one edge pass, queue what should follow
    task automatic step(input logic r, input logic s, input logic [2:0] op,
                        input logic eq, input logic [25:0] i26, input logic [15:0] i16,
                        input logic [PCW-1:0] jr, input logic [PCW-1:0] e_pc,
                        input logic e_rd, input logic e_em, input logic e_fu,
                        input string nm);
        rst       = r;
        stall     = s;
        jump_op   = op;
        cmp_eq    = eq;
        imm26     = i26;
        imm16     = i16;
        jr_target = jr;
        @(posedge clk);
        exp_q.push_back({e_pc, e_rd, e_em, e_fu});
        name_q.push_back(nm);
        #1;
    endtask

    // shorthand for an ordinary (no reset, no stall) cycle
    task automatic op_step(input logic [2:0] op, input logic eq, input logic [25:0] i26,
                           input logic [15:0] i16, input logic [PCW-1:0] jr,
                           input logic [PCW-1:0] e_pc, input logic e_rd,
                           input logic e_em, input logic e_fu, input string nm);
        step(1'b0, 1'b0, op, eq, i26, i16, jr, e_pc, e_rd, e_em, e_fu, nm);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            logic [EW-1:0] a;
            string         nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {pc, redirect, ras_empty, ras_full};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got pc=%h rd=%b em=%b fu=%b, want pc=%h rd=%b em=%b fu=%b",
                         nm, a[EW-1:3], a[2], a[1], a[0], e[EW-1:3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;

        // reset then sequential flow
        step(1'b1, 1'b0, SEQ, 1'b0, 26'h0, 16'h0, 32'h0, 32'h100, 1'b0, 1'b1, 1'b0, "reset");
        op_step(SEQ, 1'b0, 26'h0, 16'h0, 32'h0, 32'h101, 1'b0, 1'b1, 1'b0, "seq1");
        op_step(SEQ, 1'b0, 26'h0, 16'h0, 32'h0, 32'h102, 1'b0, 1'b1, 1'b0, "seq2");
        op_step(SEQ, 1'b0, 26'h0, 16'h0, 32'h0, 32'h103, 1'b0, 1'b1, 1'b0, "seq3");
        op_step(RSV, 1'b1, 26'h5, 16'h5, 32'h5, 32'h104, 1'b0, 1'b1, 1'b0, "reserved");

        // branches
        op_step(J,   1'b0, 26'h200, 16'h0,    32'h0, 32'h200, 1'b1, 1'b1, 1'b0, "j_200");
        op_step(BEQ, 1'b1, 26'h0,   16'hFFFE, 32'h0, 32'h1FF, 1'b1, 1'b1, 1'b0, "beq_taken_neg");
        op_step(J,   1'b0, 26'h200, 16'h0,    32'h0, 32'h200, 1'b1, 1'b1, 1'b0, "j_200b");
        op_step(BEQ, 1'b0, 26'h0,   16'hFFFE, 32'h0, 32'h201, 1'b0, 1'b1, 1'b0, "beq_untaken");
        op_step(BNE, 1'b0, 26'h0,   16'h0005, 32'h0, 32'h207, 1'b1, 1'b1, 1'b0, "bne_taken");
        op_step(BNE, 1'b1, 26'h0,   16'h0005, 32'h0, 32'h208, 1'b0, 1'b1, 1'b0, "bne_untaken");
        op_step(BEQ, 1'b1, 26'h0,   16'h0000, 32'h0, 32'h209, 1'b1, 1'b1, 1'b0, "beq_zero_off");
        op_step(JR,  1'b0, 26'h0,   16'h0,    32'h1234, 32'h1234, 1'b1, 1'b1, 1'b0, "jr");

        // JAL / RET pair
        op_step(J,   1'b0, 26'h10, 16'h0, 32'h0,   32'h10, 1'b1, 1'b1, 1'b0, "j_10");
        op_step(JAL, 1'b0, 26'h40, 16'h0, 32'h0,   32'h40, 1'b1, !RAS, 1'b0, "jal_40");
        op_step(RET, 1'b0, 26'h0,  16'h0, 32'h777, RAS ? 32'h11 : 32'h777, 1'b1, 1'b1, 1'b0, "ret_11");

        // overflow: five JALs from pcs 1..5 push 2..6, oldest lost
        op_step(J, 1'b0, 26'h1, 16'h0, 32'h0, 32'h1, 1'b1, 1'b1, 1'b0, "j_1");
        for (int k = 2; k <= 6; k++) begin
            op_step(JAL, 1'b0, 26'(k), 16'h0, 32'h0, 32'(k), 1'b1, !RAS, RAS && (k >= 5),
                    $sformatf("jal_push%0d", k - 1));
        end
        for (int k = 0; k < 5; k++) begin
            logic [PCW-1:0] want;
            want = (RAS && k < 4) ? 32'(6 - k) : 32'h333;
            op_step(RET, 1'b0, 26'h0, 16'h0, 32'h333, want, 1'b1, !RAS || (k >= 3), 1'b0,
                    $sformatf("ret_pop%0d", k + 1));
        end

        // stall: JAL at 0x333 pushes 0x334, then hold three cycles with J
        op_step(JAL, 1'b0, 26'h50, 16'h0, 32'h0, 32'h50, 1'b1, !RAS, 1'b0, "jal_50");
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, J, 1'b0, 26'h999, 16'h0, 32'h0, 32'h50, 1'b0, !RAS, 1'b0,
                 $sformatf("stall%0d", k + 1));
        end
        op_step(J,   1'b0, 26'h999, 16'h0, 32'h0,   32'h999, 1'b1, !RAS, 1'b0, "stall_release");
        op_step(RET, 1'b0, 26'h0,   16'h0, 32'h444, RAS ? 32'h334 : 32'h444, 1'b1, 1'b1, 1'b0,
                "ret_after_stall");

        // pc wrap
        op_step(JR,  1'b0, 26'h0, 16'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, "jr_max");
        op_step(SEQ, 1'b0, 26'h0, 16'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, "wrap");

        // reset with stall and two stacked entries
        op_step(JAL, 1'b0, 26'h10, 16'h0, 32'h0, 32'h10, 1'b1, !RAS, 1'b0, "jal_a");
        op_step(JAL, 1'b0, 26'h20, 16'h0, 32'h0, 32'h20, 1'b1, !RAS, 1'b0, "jal_b");
        step(1'b1, 1'b1, J, 1'b0, 26'h77, 16'h0, 32'h0, 32'h100, 1'b0, 1'b1, 1'b0, "reset_stall");
        op_step(RET, 1'b0, 26'h0, 16'h0, 32'h55, 32'h55, 1'b1, 1'b1, 1'b0, "ret_after_reset");
        op_step(SEQ, 1'b0, 26'h0, 16'h0, 32'h0, 32'h56, 1'b0, 1'b1, 1'b0, "seq_after_reset");

        // drain with a bound
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/next_pc.md
NEXT_PC -- requirements
Module: next_pc

Interface
REQ-001 Parameter PC_WIDTH, default 32, width of program counter (word-addressed, one increment per instruction); legal range 16..32.
REQ-002 Parameter RESET_PC, default 0, pc value loaded on reset.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries; legal range 2..16.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 stall  in  1  when 1, all state holds.
REQ-007 jump_op  in  3  operation for the instruction at current pc: 000 SEQ, 001 J, 010 BEQ, 011 BNE, 100 JAL, 101 JR, 110 RET, 111 reserved.
REQ-008 cmp_eq  in  1  operand-equality flag for BEQ/BNE.
REQ-009 imm26  in  26  absolute word target field.
REQ-010 imm16  in  16  signed word branch offset.
REQ-011 jr_target  in  PC_WIDTH  register-supplied target.
REQ-012 pc  out  PC_WIDTH  registered current pc.
REQ-013 redirect  out  1  registered; 1 for one cycle after a non-sequential pc update.
REQ-014 ras_empty  out  1  stack holds zero entries.
REQ-015 ras_full  out  1  stack holds RAS_DEPTH entries.

Function
REQ-016 Inputs are sampled at the rising edge; pc takes the selected target at that same edge (one-cycle latency, no bubbles).
REQ-017 seq = pc+1, modulo 2^PC_WIDTH; pc = all-ones wraps to 0.
REQ-018 J target: PC_WIDTH>26 gives {seq[PC_WIDTH-1:26], imm26}; otherwise imm26[PC_WIDTH-1:0].
REQ-019 BEQ target: seq + sign-extended imm16, modulo 2^PC_WIDTH, when cmp_eq=1; otherwise seq.
REQ-020 BNE target: same arithmetic as BEQ, taken when cmp_eq=0.
REQ-021 JAL target: same as J; JAL also pushes seq onto the stack.
REQ-022 JR target: jr_target; stack unchanged.
REQ-023 RET with stack non-empty: target is top entry, popped; with stack empty: target is jr_target, no stack change.
REQ-024 SEQ and 111: target seq.
REQ-025 redirect next cycle is 1 iff the chosen target came from a taken J/BEQ/BNE/JAL/JR/RET path, even if numerically equal to seq; untaken branch gives 0.
REQ-026 Push when full overwrites the oldest entry (circular), count stays RAS_DEPTH, ras_full stays 1.
REQ-027 Stack is LIFO: after N pushes (N<=RAS_DEPTH), N RETs return values in reverse push order.
REQ-028 stall=1: pc, stack, count hold; redirect driven 0; jump_op ignored.
REQ-029 ras_empty/ras_full are combinational from registered count.

Reset
REQ-030 rst=1 at an edge: pc=RESET_PC, redirect=0, stack count=0 (ras_empty=1, ras_full=0); rst overrides stall and any jump_op.
REQ-031 Reset mid-sequence discards all stack contents; the first cycle after reset release executes normally from RESET_PC.

Configuration
REQ-032 Macro NEXT_PC_RAS_EN defined: stack per REQ-021/023/026/027.
REQ-033 NEXT_PC_RAS_EN undefined: no stack storage; JAL acts as J, RET acts as JR; ras_empty tied 1, ras_full tied 0.

Verification
REQ-034 rst 1 cycle, then SEQ x3 with RESET_PC=0x100 -> pc 0x100,0x101,0x102,0x103; redirect 0 throughout.
REQ-035 pc=0x200, BEQ imm16=0xFFFE cmp_eq=1 -> pc 0x1FF, redirect 1; repeat with cmp_eq=0 -> pc 0x201, redirect 0.
REQ-036 pc=0x10, JAL imm26=0x40 then RET (stack non-empty) -> pc 0x40 then 0x11, ras_empty back to 1.
REQ-037 RAS_DEPTH=4, five JALs from pcs 1..5 then five RETs -> returns 6,5,4,3 then jr_target (oldest overwritten); ras_full after 4th push.
REQ-038 stall=1 for 3 cycles with jump_op=J -> pc and stack unchanged, redirect 0; release -> J taken.
REQ-039 pc=0xFFFFFFFF, SEQ -> pc 0; rst asserted with stall=1 and 2 stacked entries -> pc=RESET_PC, ras_empty=1.
